// File: rtl/y86_fetch_sequencer_pkg.sv
// Shared definitions for the Y86-64 fetch logic.
// Contents: icode constants, the "no register" specifier, the fetch FSM
// state type and instr_len(), which maps an icode to
// {valid, has_regs, len[3:0]}.
package y86_fetch_sequencer_pkg;

    localparam int unsigned ADDR_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    // Returns {valid, has_regs, len}. Invalid icodes report length 1 so a
    // caller that ignores 'valid' still advances the PC by one byte.
    function automatic logic [5:0] instr_len(input logic [3:0] icode);
        logic [5:0] info;
        case (icode)
            I_HALT, I_NOP, I_RET:                info = {1'b1, 1'b0, 4'd1};
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    info = {1'b1, 1'b1, 4'd2};
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        info = {1'b1, 1'b1, 4'd10};
            I_JXX, I_CALL:                       info = {1'b1, 1'b0, 4'd9};
            default:                             info = {1'b0, 1'b0, 4'd1};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/y86_fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its surroundings: the PC-update
// request (start, pc_in, busy), the byte-wide instruction memory port
// (mem_rd_en, mem_addr, mem_rd_data, mem_rd_valid) and the decoded
// instruction handed to decode (out_valid/out_ready plus fields).
// master: the fetch sequencer side.  slave: the environment side.
interface y86_fetch_sequencer_if;
    import y86_fetch_sequencer_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] pc_in;
    logic              busy;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_rd_valid;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [63:0]       valC;
    logic [63:0]       valP;
    logic              imem_error;
    logic              instr_invalid;

    modport master (
        input  start, pc_in, mem_rd_data, mem_rd_valid, out_ready,
        output busy, mem_rd_en, mem_addr, out_valid,
               icode, ifun, rA, rB, valC, valP, imem_error, instr_invalid
    );

    modport slave (
        output start, pc_in, mem_rd_data, mem_rd_valid, out_ready,
        input  busy, mem_rd_en, mem_addr, out_valid,
               icode, ifun, rA, rB, valC, valP, imem_error, instr_invalid
    );

endinterface

// File: rtl/y86_fetch_sequencer_len_decode.sv
// y86_instr_len_decode: combinational icode classifier.
// Ports: icode_i (4) in; valid_o, has_regs_o, has_valc_o (1) out;
//        len_o (4) out, instruction length in bytes.
module y86_instr_len_decode
    import y86_fetch_sequencer_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       valid_o,
    output logic       has_regs_o,
    output logic       has_valc_o,
    output logic [3:0] len_o
);

    logic [5:0] info;

    assign info       = instr_len(icode_i);
    assign valid_o    = info[5];
    assign has_regs_o = info[4];
    assign len_o      = info[3:0];
    // Every instruction of 9 or more bytes ends in an 8-byte constant.
    assign has_valc_o = info[5] && (info[3:0] >= 4'd9);

endmodule

// File: rtl/y86_fetch_sequencer.sv
// y86_fetch_sequencer: multi-cycle fetch for the sequential Y86-64 core.
// Reads the instruction one byte per memory transaction, assembles
// icode/ifun/rA/rB/valC, computes valP and reports imem_error /
// instr_invalid, then offers the result to decode with out_valid/out_ready.
// Ports: clk, rst (async, active-high) and bus (y86_fetch_sequencer_if.master).
// Parameter: MEM_BYTES, size of instruction memory; addresses at or above
// it are never read and raise imem_error.
module y86_fetch_sequencer
    import y86_fetch_sequencer_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
)
(
    input logic                     clk,
    input logic                     rst,
    y86_fetch_sequencer_if.master   bus
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    fetch_state_t state_q;
    logic [63:0]  pc_q;
    logic [3:0]   k_q;
    logic [3:0]   icode_q;
    logic [3:0]   ifun_q;
    logic [3:0]   ra_q;
    logic [3:0]   rb_q;
    logic [63:0]  valc_q;
    logic [63:0]  valp_q;
    logic         imem_err_q;
    logic         invalid_q;
    logic         busy_q;
    logic         rd_en_q;
    logic [63:0]  addr_q;
    logic         out_valid_q;

    logic [3:0]   k_d;
    logic [63:0]  cur_addr;
    logic [63:0]  next_addr_d;
    logic [3:0]   dec_icode;
    logic         dec_valid;
    logic         dec_has_regs;
    logic         dec_has_valc;
    logic [3:0]   dec_len;
    logic [2:0]   cbyte_idx;

    assign k_d         = k_q + 4'd1;
    assign cur_addr    = pc_q + {60'd0, k_q};
    assign next_addr_d = pc_q + {60'd0, k_d};

    // The first byte is classified as it arrives; later bytes use the
    // icode already captured.
    assign dec_icode = (k_q == 4'd0) ? bus.mem_rd_data[7:4] : icode_q;

    y86_instr_len_decode u_len_decode (
        .icode_i    (dec_icode),
        .valid_o    (dec_valid),
        .has_regs_o (dec_has_regs),
        .has_valc_o (dec_has_valc),
        .len_o      (dec_len)
    );

    // Constant byte j sits after the icode byte and optional register byte.
    // Modulo-8 arithmetic on k's low bits is exact for k in 1..9.
    assign cbyte_idx = k_q[2:0] - (dec_has_regs ? 3'd2 : 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            k_q         <= '0;
            icode_q     <= '0;
            ifun_q      <= '0;
            ra_q        <= REG_NONE;
            rb_q        <= REG_NONE;
            valc_q      <= '0;
            valp_q      <= '0;
            imem_err_q  <= 1'b0;
            invalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pc_q       <= bus.pc_in;
                        k_q        <= 4'd0;
                        icode_q    <= '0;
                        ifun_q     <= '0;
                        ra_q       <= REG_NONE;
                        rb_q       <= REG_NONE;
                        valc_q     <= '0;
                        valp_q     <= '0;
                        imem_err_q <= 1'b0;
                        invalid_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_REQ;
                        // The read strobe is registered, so it is raised on
                        // entry to REQ; an out-of-range byte never gets one.
                        if (bus.pc_in < MEM_LIMIT) begin
                            rd_en_q <= 1'b1;
                            addr_q  <= bus.pc_in;
                        end
                    end
                end

                ST_REQ: begin
                    rd_en_q <= 1'b0;
                    if (cur_addr >= MEM_LIMIT) begin
                        // Unreadable byte: report as a nop with error.
                        imem_err_q  <= 1'b1;
                        icode_q     <= I_NOP;
                        ifun_q      <= 4'h0;
                        ra_q        <= REG_NONE;
                        rb_q        <= REG_NONE;
                        valc_q      <= '0;
                        valp_q      <= pc_q + 64'd1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        if (k_q == 4'd0) begin
                            icode_q <= bus.mem_rd_data[7:4];
                            ifun_q  <= bus.mem_rd_data[3:0];
                        end else if ((k_q == 4'd1) && dec_has_regs) begin
                            ra_q <= bus.mem_rd_data[7:4];
                            rb_q <= bus.mem_rd_data[3:0];
                        end else if (dec_has_valc) begin
                            valc_q[{cbyte_idx, 3'b000} +: 8] <= bus.mem_rd_data;
                        end

                        if (!dec_valid) begin
                            invalid_q   <= 1'b1;
                            valp_q      <= pc_q + 64'd1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (k_d == dec_len) begin
                            valp_q      <= pc_q + {60'd0, dec_len};
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            k_q     <= k_d;
                            state_q <= ST_REQ;
                            if (next_addr_d < MEM_LIMIT) begin
                                rd_en_q <= 1'b1;
                                addr_q  <= next_addr_d;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.mem_rd_en     = rd_en_q;
    assign bus.mem_addr      = addr_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.icode         = icode_q;
    assign bus.ifun          = ifun_q;
    assign bus.rA            = ra_q;
    assign bus.rB            = rb_q;
    assign bus.valC          = valc_q;
    assign bus.valP          = valp_q;
    assign bus.imem_error    = imem_err_q;
    assign bus.instr_invalid = invalid_q;

endmodule
